// File: rtl/ureg_pkg.sv
// rtl/ureg_pkg.sv - mode encodings shared by universal_register and its bench
package ureg_pkg;
  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_HOLD   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL    = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_INC    = 3'd4;
  localparam logic [MODE_W-1:0] MODE_DEC    = 3'd5;
  localparam logic [MODE_W-1:0] MODE_TOGGLE = 3'd6;
  localparam logic [MODE_W-1:0] MODE_JK     = 3'd7;
endpackage

// File: rtl/ureg_jk_cell.sv
// rtl/ureg_jk_cell.sv - single-bit JK next-state: 00 hold, 01 clear, 10 set, 11 toggle
module ureg_jk_cell (
  input  logic q,
  input  logic j,
  input  logic k,
  output logic q_next
);
  assign q_next = (j & ~q) | (~k & q);
endmodule

// File: rtl/universal_register.sv
// rtl/universal_register.sv - multi-mode hold/load/shift/count/toggle/JK register
// UREG_SATURATE_EN: INC/DEC stop at the boundary instead of wrapping.
module universal_register
  import ureg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              ar,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic              ser_in,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qhat,
  output logic              ser_out,
  output logic              tc,
  output logic              ovf
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] shl_next;
  logic [WIDTH-1:0] shr_next;
  logic [WIDTH-1:0] nxt;
  logic             all_ones;
  logic             all_zero;

  for (genvar i = 0; i < WIDTH; i++) begin : g_jk
    ureg_jk_cell u_cell (
      .q      (q[i]),
      .j      (j[i]),
      .k      (k[i]),
      .q_next (jk_next[i])
    );
  end

  // A one-bit register has no neighbour bits to shift, so both directions just take ser_in.
  if (WIDTH == 1) begin : g_shift_w1
    assign shl_next = {WIDTH{ser_in}};
    assign shr_next = {WIDTH{ser_in}};
  end else begin : g_shift
    assign shl_next = {q[WIDTH-2:0], ser_in};
    assign shr_next = {ser_in, q[WIDTH-1:1]};
  end

  assign all_ones = &q;
  assign all_zero = ~|q;
  assign qhat     = ~q;
  assign tc       = ((mode == MODE_INC) && all_ones) || ((mode == MODE_DEC) && all_zero);

  always_comb begin
    ser_out = 1'b0;
    if (mode == MODE_SHL) ser_out = q[WIDTH-1];
    else if (mode == MODE_SHR) ser_out = q[0];
  end

  always_comb begin
    nxt = q;
    case (mode)
      MODE_HOLD:   nxt = q;
      MODE_LOAD:   nxt = d;
      MODE_SHL:    nxt = shl_next;
      MODE_SHR:    nxt = shr_next;
`ifdef UREG_SATURATE_EN
      MODE_INC:    nxt = all_ones ? q : q + ONE;
      MODE_DEC:    nxt = all_zero ? q : q - ONE;
`else
      MODE_INC:    nxt = q + ONE;
      MODE_DEC:    nxt = q - ONE;
`endif
      MODE_TOGGLE: nxt = q ^ d;
      MODE_JK:     nxt = jk_next;
      default:     nxt = q;
    endcase
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      if (en) q <= nxt;
      ovf <= en & tc;
    end
  end
endmodule

// File: tb/tb_universal_register.sv
// tb/tb_universal_register.sv - self-checking bench for universal_register (WIDTH=4 and WIDTH=1)
module tb_universal_register;
  import ureg_pkg::*;

  logic       clk = 1'b0;
  logic       ar  = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] mode = MODE_HOLD;
  logic [3:0] d = '0, j = '0, k = '0;
  logic       ser_in = 1'b0;
  logic [3:0] q, qhat;
  logic       ser_out, tc, ovf;

  logic       en1 = 1'b0;
  logic [2:0] mode1 = MODE_HOLD;
  logic [0:0] d1 = '0, j1 = '0, k1 = '0;
  logic       ser_in1 = 1'b0;
  logic [0:0] q1, qhat1;
  logic       ser_out1, tc1, ovf1;

  int checks = 0;
  int errors = 0;

  int mq;
  bit movf;

  always #5 clk = ~clk;

  universal_register #(.WIDTH(4)) dut (
    .clk(clk), .ar(ar), .en(en), .mode(mode), .d(d), .j(j), .k(k), .ser_in(ser_in),
    .q(q), .qhat(qhat), .ser_out(ser_out), .tc(tc), .ovf(ovf)
  );

  universal_register #(.WIDTH(1)) dut1 (
    .clk(clk), .ar(ar), .en(en1), .mode(mode1), .d(d1), .j(j1), .k(k1), .ser_in(ser_in1),
    .q(q1), .qhat(qhat1), .ser_out(ser_out1), .tc(tc1), .ovf(ovf1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit at_boundary(input int m, input int v);
    return (m == MODE_INC && v == 15) || (m == MODE_DEC && v == 0);
  endfunction

  // Next state from the arithmetic meaning of each mode on a 4-bit value.
  function automatic int model_next(input int m, input int v, input int dd, input int jj,
                                    input int kk, input int si);
    int r;
    case (m)
      MODE_LOAD:   r = dd;
      MODE_SHL:    r = (v * 2 + si) % 16;
      MODE_SHR:    r = v / 2 + si * 8;
      MODE_TOGGLE: r = v ^ dd;
      MODE_JK: begin
        r = 0;
        for (int b = 0; b < 4; b++) begin
          int qb, jb, kb, nb;
          qb = (v >> b) & 1; jb = (jj >> b) & 1; kb = (kk >> b) & 1;
          if (jb == 0 && kb == 0) nb = qb;
          else if (jb == 0) nb = 0;
          else if (kb == 0) nb = 1;
          else nb = 1 - qb;
          r += nb << b;
        end
      end
`ifdef UREG_SATURATE_EN
      MODE_INC:    r = (v == 15) ? 15 : v + 1;
      MODE_DEC:    r = (v == 0) ? 0 : v - 1;
`else
      MODE_INC:    r = (v + 1) % 16;
      MODE_DEC:    r = (v + 15) % 16;
`endif
      default:     r = v;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge ar) begin
    if (ar) begin
      mq   <= 0;
      movf <= 1'b0;
    end else if (en) begin
      mq   <= model_next(int'(mode), mq, int'(d), int'(j), int'(k), int'(ser_in));
      movf <= at_boundary(int'(mode), mq);
    end else begin
      movf <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int exp_so;
    exp_so = (mode == MODE_SHL) ? (mq >> 3) & 1 : (mode == MODE_SHR) ? mq & 1 : 0;
    check("q",       int'(q),       mq);
    check("qhat",    int'(qhat),    15 - mq);
    check("ser_out", int'(ser_out), exp_so);
    check("tc",      int'(tc),      int'(at_boundary(int'(mode), mq)));
    check("ovf",     int'(ovf),     int'(movf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    en = 1'b1; mode = MODE_LOAD; d = v;
    step();
  endtask

  initial begin
    repeat (2) step();
    check("rst_q", int'(q), 0);
    check("rst_qhat", int'(qhat), 15);
    check("rst_ovf", int'(ovf), 0);
    ar = 1'b0;

    load(4'h9);
    check("load9", int'(q), 9);
    en = 1'b1; mode = MODE_INC;
    #3 ar = 1'b1;
    #1;
    check("async_q", int'(q), 0);
    check("async_qhat", int'(qhat), 15);
    check("async_ovf", int'(ovf), 0);
    step();
    ar = 1'b0;
    step();
    check("inc_after_rst", int'(q), 1);

    load(4'h0);
    en = 1'b0; mode = MODE_LOAD; d = 4'hA;
    repeat (3) step();
    check("en0_hold", int'(q), 0);
    en = 1'b1;
    step();
    check("loadA", int'(q), 10);
    mode = MODE_TOGGLE; d = 4'hF;
    step();
    check("toggle", int'(q), 5);

    load(4'h0);
    mode = MODE_SHL;
    ser_in = 1'b1; step(); check("shl1", int'(q), 1);
    ser_in = 1'b0; step(); check("shl2", int'(q), 2);
    ser_in = 1'b1; step(); check("shl5", int'(q), 5);
    ser_in = 1'b1; step(); check("shlB", int'(q), 11);
    mode = MODE_SHR; ser_in = 1'b0;
    #1 check("shr_ser_out", int'(ser_out), 1);
    step();
    check("shr5", int'(q), 5);

    load(4'hE);
    mode = MODE_INC;
    step();
    check("incF", int'(q), 15);
    check("incF_tc", int'(tc), 1);
    step();
`ifdef UREG_SATURATE_EN
    check("inc_sat", int'(q), 15);
`else
    check("inc_wrap", int'(q), 0);
`endif
    check("inc_ovf", int'(ovf), 1);
    mode = MODE_HOLD;
    step();
    check("ovf_pulse_end", int'(ovf), 0);

    load(4'h0);
    mode = MODE_DEC;
    #1 check("dec_tc", int'(tc), 1);
    step();
`ifdef UREG_SATURATE_EN
    check("dec_sat", int'(q), 0);
`else
    check("dec_wrap", int'(q), 15);
`endif
    check("dec_ovf", int'(ovf), 1);
    en = 1'b0;
    step();
    check("en0_ovf", int'(ovf), 0);

    load(4'hC);
    mode = MODE_JK; j = 4'hA; k = 4'h6;
    step();
    check("jk", int'(q), 10);

    for (int m = 0; m < 8; m++) begin
      mode = 3'(m); d = 4'h3; j = 4'h5; k = 4'h9; ser_in = m[0];
      step();
    end
    en = 1'b0;

    en1 = 1'b1; mode1 = MODE_SHL; ser_in1 = 1'b1;
    step(); check("w1_shl", int'(q1), 1);
    mode1 = MODE_LOAD; d1 = 1'b0;
    step(); check("w1_load0", int'(q1), 0);
    mode1 = MODE_SHR;
    step(); check("w1_shr", int'(q1), 1);
    mode1 = MODE_INC;
    #1 check("w1_tc", int'(tc1), 1);
    step();
`ifdef UREG_SATURATE_EN
    check("w1_inc_sat", int'(q1), 1);
`else
    check("w1_inc_wrap", int'(q1), 0);
`endif
    check("w1_ovf", int'(ovf1), 1);
    en1 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
